fsm_dispatcher: RTL and testbench

Instruction dispatcher that sequences the per-operation FSMs (register ALU, immediate ALU, memory, move) sharing the single tri-state data bus. It accepts one instruction word per valid/ready handshake and decodes it to a unit. It then pulses that unit's start, grants it exclusive bus ownership, and waits for its done. A watchdog aborts hung operations, and retire/halt/error status goes to the top level.

---
 rtl/dispatch_pkg.sv | 59 +++++
 rtl/dispatch_watchdog.sv | 33 +++
 rtl/fsm_dispatcher.sv | 162 ++++++++++++++++
 tb/tb_fsm_dispatcher.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared definitions for the instruction dispatcher: opcode ranges, unit
// indices, FSM state encoding and instruction field positions.
package dispatch_pkg;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int P1_MSB  = 27;
    localparam int P1_LSB  = 22;
    localparam int P2_MSB  = 21;
    localparam int P2_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_REG_LO = 4'h1;
    localparam logic [3:0] OP_REG_HI = 4'h7;
    localparam logic [3:0] OP_IMM_LO = 4'h8;
    localparam logic [3:0] OP_IMM_HI = 4'hB;
    localparam logic [3:0] OP_MEM_LO = 4'hC;
    localparam logic [3:0] OP_MEM_HI = 4'hD;
    localparam logic [3:0] OP_MOV    = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [1:0] UNIT_REG = 2'd0;
    localparam logic [1:0] UNIT_IMM = 2'd1;
    localparam logic [1:0] UNIT_MEM = 2'd2;
    localparam logic [1:0] UNIT_MOV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RETIRE = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    // NOP and HALT never reach a unit, so their mapping is irrelevant.
    function automatic logic [1:0] decode_unit(input logic [3:0] op);
        logic [1:0] u;
        if (op >= OP_REG_LO && op <= OP_REG_HI) begin
            u = UNIT_REG;
        end else if (op >= OP_IMM_LO && op <= OP_IMM_HI) begin
            u = UNIT_IMM;
        end else if (op >= OP_MEM_LO && op <= OP_MEM_HI) begin
            u = UNIT_MEM;
        end else if (op == OP_MOV) begin
            u = UNIT_MOV;
        end else begin
            u = UNIT_REG;
        end
        return u;
    endfunction

    function automatic logic [3:0] unit_onehot(input logic [1:0] u);
        return 4'b0001 << u;
    endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// Cycle counter for operations in flight; expire flags the last permitted
// cycle so the dispatcher can abort on that same edge.
module dispatch_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CW    = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count enabled cycles since the last clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= {CW{1'b0}};
        end else if (clear) begin
            r_count <= {CW{1'b0}};
        end else if (enable) begin
            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign expire = enable && (r_count == LIMIT);

endmodule

// File: rtl/fsm_dispatcher.sv
// Instruction dispatcher: accepts one instruction per handshake, starts the
// decoded unit, owns the shared-bus grant, and retires on done or timeout.
module fsm_dispatcher
    import dispatch_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    output logic [3:0]         unit_start,
    input  logic [3:0]         unit_done,
    output logic [3:0]         bus_grant,
    output logic [3:0]         opcode,
    output logic [5:0]         param1,
    output logic [5:0]         param2,
    output logic [15:0]        immediate,
    output logic               retired,
    output logic [COUNT_W-1:0] retired_count,
    output logic               halted,
    output logic               error
);

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_unit;
    logic [1:0]          w_unit_cur;
    logic [3:0]          r_opcode;
    logic [5:0]          r_param1;
    logic [5:0]          r_param2;
    logic [15:0]         r_immediate;
    logic                r_instr_ready;
    logic [3:0]          r_unit_start;
    logic [3:0]          r_bus_grant;
    logic                r_retired;
    logic [COUNT_W-1:0]  r_retired_count;
    logic                r_halted;
    logic                r_error;
    logic                w_done;
    logic                w_expire;
    logic                w_timeout;
    logic                w_accept;

    dispatch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (r_state == ST_START),
        .enable (r_state == ST_WAIT),
        .expire (w_expire)
    );

    assign w_accept   = (r_state == ST_IDLE) && instr_valid;
    // The unit index is latched on leaving DECODE, so bypass it on that edge.
    assign w_unit_cur = (r_state == ST_DECODE) ? decode_unit(r_opcode) : r_unit;
    assign w_done     = (r_state == ST_WAIT) && unit_done[r_unit];
    assign w_timeout  = (r_state == ST_WAIT) && !w_done && w_expire;

    // Next-state logic; done takes priority over a coincident timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_state_next = ST_DECODE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (r_opcode == OP_NOP) begin
                    w_state_next = ST_RETIRE;
                end else if (r_opcode == OP_HALT) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = ST_START;
                end
            end
            ST_START: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_done) begin
                    w_state_next = ST_RETIRE;
                end else if (w_expire) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_RETIRE: w_state_next = ST_IDLE;
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // State, latched instruction fields and unit index.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_unit      <= UNIT_REG;
            r_opcode    <= 4'h0;
            r_param1    <= 6'd0;
            r_param2    <= 6'd0;
            r_immediate <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_opcode    <= instr[OP_MSB:OP_LSB];
                r_param1    <= instr[P1_MSB:P1_LSB];
                r_param2    <= instr[P2_MSB:P2_LSB];
                r_immediate <= instr[IMM_MSB:IMM_LSB];
            end
            if (r_state == ST_DECODE) begin
                r_unit <= decode_unit(r_opcode);
            end
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr_ready   <= 1'b1;
            r_unit_start    <= 4'b0000;
            r_bus_grant     <= 4'b0000;
            r_retired       <= 1'b0;
            r_retired_count <= {COUNT_W{1'b0}};
            r_halted        <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_instr_ready <= (w_state_next == ST_IDLE);
            r_unit_start  <= (w_state_next == ST_START) ? unit_onehot(w_unit_cur) : 4'b0000;
            r_bus_grant   <= (w_state_next == ST_START || w_state_next == ST_WAIT)
                             ? unit_onehot(w_unit_cur) : 4'b0000;
            r_retired     <= (w_state_next == ST_RETIRE);
            if (w_state_next == ST_RETIRE) begin
                r_retired_count <= r_retired_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
            if (w_state_next == ST_HALTED) begin
                r_halted <= 1'b1;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign instr_ready   = r_instr_ready;
    assign unit_start    = r_unit_start;
    assign bus_grant     = r_bus_grant;
    assign opcode        = r_opcode;
    assign param1        = r_param1;
    assign param2        = r_param2;
    assign immediate     = r_immediate;
    assign retired       = r_retired;
    assign retired_count = r_retired_count;
    assign halted        = r_halted;
    assign error         = r_error;

endmodule

// File: tb/tb_fsm_dispatcher.sv
// Directed self-checking bench for fsm_dispatcher: unit done pulses are
// driven by hand at the cycle the scenario calls for.
module tb_fsm_dispatcher;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  unit_start;
    logic [3:0]  unit_done;
    logic [3:0]  bus_grant;
    logic [3:0]  opcode;
    logic [5:0]  param1;
    logic [5:0]  param2;
    logic [15:0] immediate;
    logic        retired;
    logic [15:0] retired_count;
    logic        halted;
    logic        error;

    int total = 0;
    int bad   = 0;

    fsm_dispatcher #(.TIMEOUT(64), .COUNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .unit_start    (unit_start),
        .unit_done     (unit_done),
        .bus_grant     (bus_grant),
        .opcode        (opcode),
        .param1        (param1),
        .param2        (param2),
        .immediate     (immediate),
        .retired       (retired),
        .retired_count (retired_count),
        .halted        (halted),
        .error         (error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        unit_done   = 4'b0000;
        tick();
        tick();
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_start", {28'd0, unit_start}, 32'd0);
        check("rst_grant", {28'd0, bus_grant}, 32'd0);
        check("rst_retired", {31'd0, retired}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_count", {16'd0, retired_count}, 32'd0);
        check("rst_imm", {16'd0, immediate}, 32'd0);
        check("rst_opcode", {28'd0, opcode}, 32'd0);
        reset = 1'b0;

        // Immediate-ALU op, unit answers 10 cycles after start
        instr       = {4'h8, 6'd5, 6'd0, 16'h1234};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("imm_dec_ready", {31'd0, instr_ready}, 32'd0);
        check("imm_dec_opcode", {28'd0, opcode}, 32'h8);
        check("imm_dec_p1", {26'd0, param1}, 32'd5);
        check("imm_dec_imm", {16'd0, immediate}, 32'h1234);
        check("imm_dec_start", {28'd0, unit_start}, 32'd0);
        tick();
        check("imm_start", {28'd0, unit_start}, 32'b0010);
        check("imm_start_grant", {28'd0, bus_grant}, 32'b0010);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("imm_wait_grant", {28'd0, bus_grant}, 32'b0010);
            check("imm_wait_start", {28'd0, unit_start}, 32'd0);
            check("imm_wait_ret", {31'd0, retired}, 32'd0);
        end
        tick();
        unit_done = 4'b0010;
        check("imm_wait10_grant", {28'd0, bus_grant}, 32'b0010);
        tick();
        unit_done = 4'b0000;
        check("imm_retired", {31'd0, retired}, 32'd1);
        check("imm_count", {16'd0, retired_count}, 32'd1);
        check("imm_ret_grant", {28'd0, bus_grant}, 32'd0);
        check("imm_ret_imm", {16'd0, immediate}, 32'h1234);
        tick();
        check("imm_idle_ready", {31'd0, instr_ready}, 32'd1);
        check("imm_idle_ret", {31'd0, retired}, 32'd0);

        // Three NOPs with valid held high
        instr       = 32'h0;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nop_dec_ret", {31'd0, retired}, 32'd0);
            check("nop_dec_start", {28'd0, unit_start}, 32'd0);
            tick();
            check("nop_retired", {31'd0, retired}, 32'd1);
            check("nop_grant", {28'd0, bus_grant}, 32'd0);
            check("nop_count", {16'd0, retired_count}, 32'(2 + i));
            tick();
            check("nop_ready", {31'd0, instr_ready}, 32'd1);
            check("nop_idle_start", {28'd0, unit_start}, 32'd0);
        end

        // Memory op that never finishes: watchdog abort
        instr = {4'hC, 6'd1, 6'd2, 16'h00AA};
        tick();
        instr_valid = 1'b0;
        tick();
        check("mem_start", {28'd0, unit_start}, 32'b0100);
        tick();
        for (int i = 1; i < 64; i++) begin
            tick();
            check("mem_wait_grant", {28'd0, bus_grant}, 32'b0100);
            check("mem_wait_err", {31'd0, error}, 32'd0);
        end
        tick();
        check("mem_to_error", {31'd0, error}, 32'd1);
        check("mem_to_grant", {28'd0, bus_grant}, 32'd0);
        check("mem_to_ret", {31'd0, retired}, 32'd0);
        check("mem_to_count", {16'd0, retired_count}, 32'd4);
        check("mem_to_ready", {31'd0, instr_ready}, 32'd1);

        // Reg-ALU op after an error still completes
        instr       = {4'h1, 6'd3, 6'd4, 16'h0000};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("reg_start", {28'd0, unit_start}, 32'b0001);
        tick();
        unit_done = 4'b0001;
        tick();
        unit_done = 4'b0000;
        check("reg_retired", {31'd0, retired}, 32'd1);
        check("reg_count", {16'd0, retired_count}, 32'd5);
        check("reg_error_kept", {31'd0, error}, 32'd1);
        tick();

        // Move op with early and foreign done pulses
        instr       = {4'hE, 6'd7, 6'd8, 16'h0000};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        unit_done   = 4'b1111;
        tick();
        check("mov_start", {28'd0, unit_start}, 32'b1000);
        check("mov_start_grant", {28'd0, bus_grant}, 32'b1000);
        tick();
        unit_done = 4'b0100;
        check("mov_early_done_ignored", {31'd0, retired}, 32'd0);
        check("mov_wait_grant", {28'd0, bus_grant}, 32'b1000);
        tick();
        unit_done = 4'b1000;
        check("mov_spurious_ignored", {31'd0, retired}, 32'd0);
        check("mov_grant_held", {28'd0, bus_grant}, 32'b1000);
        tick();
        unit_done = 4'b0000;
        check("mov_retired", {31'd0, retired}, 32'd1);
        check("mov_count", {16'd0, retired_count}, 32'd6);
        tick();

        // HALT is absorbing until reset
        instr       = {4'hF, 28'h0};
        instr_valid = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_halted", {31'd0, halted}, 32'd1);
            check("halt_ready", {31'd0, instr_ready}, 32'd0);
            check("halt_grant", {28'd0, bus_grant}, 32'd0);
        end
        instr_valid = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("halt_rst_error", {31'd0, error}, 32'd0);
        check("halt_rst_count", {16'd0, retired_count}, 32'd0);

        // Reset in the middle of WAIT
        instr       = {4'h2, 6'd1, 6'd1, 16'h0000};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_grant_before", {28'd0, bus_grant}, 32'b0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_grant", {28'd0, bus_grant}, 32'd0);
        check("midrst_start", {28'd0, unit_start}, 32'd0);
        check("midrst_count", {16'd0, retired_count}, 32'd0);
        tick();
        check("midrst_ready", {31'd0, instr_ready}, 32'd1);

        // Done coincident with the timeout threshold
        instr       = {4'hD, 6'd2, 6'd3, 16'h0000};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 64; i++) begin
            tick();
        end
        unit_done = 4'b0100;
        check("coinc_grant", {28'd0, bus_grant}, 32'b0100);
        tick();
        unit_done = 4'b0000;
        check("coinc_retired", {31'd0, retired}, 32'd1);
        check("coinc_error", {31'd0, error}, 32'd0);
        check("coinc_count", {16'd0, retired_count}, 32'd1);
        tick();
        check("coinc_ready", {31'd0, instr_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
